// File: rtl/burst_ram_arbiter_if.sv
// Bundle of the two cache-client ports and the burst RAM controller port.
// The arbiter uses the slave view; clients and RAM model use the master view.
interface burst_ram_arbiter_if #(
    parameter int AW = 21
);
    logic          c0_req;
    logic          c0_cmd;
    logic [AW-1:0] c0_addr;
    logic [63:0]   c0_wr_data;
    logic          c0_gnt;
    logic [63:0]   c0_rd_data;
    logic          c0_rd_data_valid;
    logic          c0_done;

    logic          c1_req;
    logic          c1_cmd;
    logic [AW-1:0] c1_addr;
    logic [63:0]   c1_wr_data;
    logic          c1_gnt;
    logic [63:0]   c1_rd_data;
    logic          c1_rd_data_valid;
    logic          c1_done;

    logic          br_cmd;
    logic          br_cmd_en;
    logic [AW-1:0] br_addr;
    logic [63:0]   br_wr_data;
    logic [7:0]    br_data_mask;
    logic [63:0]   br_rd_data;
    logic          br_rd_data_valid;

    modport slave (
        input  c0_req, c0_cmd, c0_addr, c0_wr_data,
        input  c1_req, c1_cmd, c1_addr, c1_wr_data,
        input  br_rd_data, br_rd_data_valid,
        output c0_gnt, c0_rd_data, c0_rd_data_valid, c0_done,
        output c1_gnt, c1_rd_data, c1_rd_data_valid, c1_done,
        output br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask
    );

    modport master (
        output c0_req, c0_cmd, c0_addr, c0_wr_data,
        output c1_req, c1_cmd, c1_addr, c1_wr_data,
        output br_rd_data, br_rd_data_valid,
        input  c0_gnt, c0_rd_data, c0_rd_data_valid, c0_done,
        input  c1_gnt, c1_rd_data, c1_rd_data_valid, c1_done,
        input  br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask
    );
endinterface

// File: rtl/burst_ram_arbiter.sv
// Round-robin arbiter sharing one burst RAM controller port between two cache clients,
// one whole burst at a time, with a global minimum spacing between commands.
module burst_ram_arbiter #(
    parameter int RAM_DEPTH_BITWIDTH     = 21,
    parameter int COMMAND_DELAY_INTERVAL = 13,
    parameter int BURST_BEATS            = 4
) (
    input logic                 clk,
    input logic                 rst,
    burst_ram_arbiter_if.slave  bus
);
    localparam logic [5:0] DLY_INIT  = 6'(COMMAND_DELAY_INTERVAL);
    localparam logic [2:0] BEAT_LAST = 3'(BURST_BEATS - 1);

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_e;

    state_e                        state_q, state_d;
    logic                          owner_q, owner_d;
    logic                          last_owner_q, last_owner_d;
    logic [5:0]                    dly_cnt_q, dly_cnt_d;
    logic [2:0]                    beat_q, beat_d;
    logic                          br_cmd_en_q, br_cmd_en_d;
    logic                          br_cmd_q, br_cmd_d;
    logic [RAM_DEPTH_BITWIDTH-1:0] br_addr_q, br_addr_d;
    logic [1:0]                    gnt_q, gnt_d;
    logic [1:0]                    done_q, done_d;

    logic [1:0] req;
    logic       sel;

    assign req = {bus.c1_req, bus.c0_req};
    // Both requesting: the client that did not win last time gets the burst.
    assign sel = (req == 2'b11) ? ~last_owner_q : req[1];

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        dly_cnt_d    = (dly_cnt_q != 6'd0) ? dly_cnt_q - 6'd1 : 6'd0;
        beat_d       = beat_q;
        br_cmd_en_d  = 1'b0;
        br_cmd_d     = br_cmd_q;
        br_addr_d    = br_addr_q;
        gnt_d        = 2'b00;
        done_d       = 2'b00;
        case (state_q)
            IDLE: begin
                if (dly_cnt_q == 6'd0 && req != 2'b00) begin
                    br_cmd_en_d  = 1'b1;
                    br_cmd_d     = sel ? bus.c1_cmd : bus.c0_cmd;
                    br_addr_d    = sel ? bus.c1_addr : bus.c0_addr;
                    gnt_d[sel]   = 1'b1;
                    owner_d      = sel;
                    last_owner_d = sel;
                    dly_cnt_d    = DLY_INIT;
                    beat_d       = 3'd0;
                    state_d      = (sel ? bus.c1_cmd : bus.c0_cmd) ? WRITE : READ;
                end
            end
            WRITE: begin
                beat_d = beat_q + 3'd1;
                if (beat_q == BEAT_LAST) begin
                    done_d[owner_q] = 1'b1;
                    state_d         = IDLE;
                end
            end
            READ: begin
                if (bus.br_rd_data_valid) begin
                    beat_d = beat_q + 3'd1;
                    if (beat_q == BEAT_LAST) begin
                        done_d[owner_q] = 1'b1;
                        state_d         = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            dly_cnt_q    <= 6'd0;
            beat_q       <= 3'd0;
            br_cmd_en_q  <= 1'b0;
            br_cmd_q     <= 1'b0;
            br_addr_q    <= '0;
            gnt_q        <= 2'b00;
            done_q       <= 2'b00;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            dly_cnt_q    <= dly_cnt_d;
            beat_q       <= beat_d;
            br_cmd_en_q  <= br_cmd_en_d;
            br_cmd_q     <= br_cmd_d;
            br_addr_q    <= br_addr_d;
            gnt_q        <= gnt_d;
            done_q       <= done_d;
        end
    end

    assign bus.br_cmd_en    = br_cmd_en_q;
    assign bus.br_cmd       = br_cmd_q;
    assign bus.br_addr      = br_addr_q;
    assign bus.br_data_mask = 8'h00;
    // Write beats flow straight from the owner; the RAM samples them in T..T+BURST_BEATS-1.
    assign bus.br_wr_data   = (state_q != WRITE) ? 64'd0 :
                              (owner_q ? bus.c1_wr_data : bus.c0_wr_data);

    assign bus.c0_gnt  = gnt_q[0];
    assign bus.c1_gnt  = gnt_q[1];
    assign bus.c0_done = done_q[0];
    assign bus.c1_done = done_q[1];

    assign bus.c0_rd_data       = bus.br_rd_data;
    assign bus.c1_rd_data       = bus.br_rd_data;
    assign bus.c0_rd_data_valid = bus.br_rd_data_valid && (state_q == READ) && !owner_q;
    assign bus.c1_rd_data_valid = bus.br_rd_data_valid && (state_q == READ) &&  owner_q;
endmodule

// File: tb/tb_burst_ram_arbiter.sv
// Directed bench for burst_ram_arbiter: grants, burst data routing, command spacing,
// round-robin fairness, mid-burst reset and stray read beats.
module tb_burst_ram_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    burst_ram_arbiter_if #(.AW(21)) bus ();

    burst_ram_arbiter #(
        .RAM_DEPTH_BITWIDTH(21),
        .COMMAND_DELAY_INTERVAL(13),
        .BURST_BEATS(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Enter the next cycle just after its rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Advance until a command strobe is seen; returns its cycle number.
    task automatic wait_cmd(output int t);
        t = -1;
        for (int i = 0; i < 40; i++) begin
            step();
            #1;
            if (bus.br_cmd_en) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) chk("cmd_timeout", {63'd0, bus.br_cmd_en}, 64'd1);
    endtask

    int t0, t1, t2, t3;

    initial begin
        bus.c0_req = 0; bus.c0_cmd = 0; bus.c0_addr = '0; bus.c0_wr_data = '0;
        bus.c1_req = 0; bus.c1_cmd = 0; bus.c1_addr = '0; bus.c1_wr_data = '0;
        bus.br_rd_data = '0; bus.br_rd_data_valid = 0;

        // reset values
        idle(2);
        #1;
        chk("rst_cmd_en", {63'd0, bus.br_cmd_en}, 64'd0);
        chk("rst_gnt", {62'd0, bus.c1_gnt, bus.c0_gnt}, 64'd0);
        chk("rst_done", {62'd0, bus.c1_done, bus.c0_done}, 64'd0);
        chk("rst_addr_cmd", {42'd0, bus.br_addr, bus.br_cmd}, 64'd0);
        chk("rst_wr_data", bus.br_wr_data, 64'd0);
        chk("rst_mask", {56'd0, bus.br_data_mask}, 64'd0);
        rst = 0;

        // 1: c0 read alone, one stall cycle between beats 2 and 3
        step();
        bus.c0_req = 1; bus.c0_cmd = 0; bus.c0_addr = 21'h000100;
        wait_cmd(t0);
        chk("t1_addr", {43'd0, bus.br_addr}, 64'h100);
        chk("t1_cmd", {63'd0, bus.br_cmd}, 64'd0);
        chk("t1_gnt", {62'd0, bus.c1_gnt, bus.c0_gnt}, 64'b01);
        bus.c0_req = 0;
        step(); #1;
        chk("t1_cmd_en_drop", {62'd0, bus.br_cmd_en, bus.c0_gnt}, 64'd0);
        for (int k = 1; k <= 5; k++) begin
            if (k != 3) begin
                step();
                bus.br_rd_data_valid = 1; bus.br_rd_data = 64'hA000 + 64'(k);
                #1;
                chk("t1_beat_valid", {62'd0, bus.c1_rd_data_valid, bus.c0_rd_data_valid}, 64'b01);
                chk("t1_beat_data", bus.c0_rd_data, 64'hA000 + 64'(k));
            end else begin
                step();
                bus.br_rd_data_valid = 0;
                #1;
                chk("t1_no_early_done", {63'd0, bus.c0_done}, 64'd0);
            end
        end
        step();
        bus.br_rd_data_valid = 0;
        #1;
        chk("t1_done", {62'd0, bus.c1_done, bus.c0_done}, 64'b01);
        step(); #1;
        chk("t1_done_pulse", {63'd0, bus.c0_done}, 64'd0);
        idle(12);

        // 2: c0 write, stray read beats during the write are not routed
        bus.c0_req = 1; bus.c0_cmd = 1; bus.c0_addr = 21'h000200;
        bus.c0_wr_data = 64'h1111111111111111;
        wait_cmd(t0);
        chk("t2_cmd", {43'd0, bus.br_addr, bus.br_cmd}, {43'd0, 21'h000200, 1'b1});
        chk("t2_beat0", bus.br_wr_data, 64'h1111111111111111);
        bus.c0_req = 0;
        step();
        bus.c0_wr_data = 64'h2222222222222222; bus.br_rd_data_valid = 1;
        #1;
        chk("t2_beat1", bus.br_wr_data, 64'h2222222222222222);
        chk("t2_no_rd_valid", {62'd0, bus.c1_rd_data_valid, bus.c0_rd_data_valid}, 64'd0);
        step();
        bus.c0_wr_data = 64'h3333333333333333;
        #1;
        chk("t2_beat2", bus.br_wr_data, 64'h3333333333333333);
        step();
        bus.c0_wr_data = 64'h4444444444444444;
        #1;
        chk("t2_beat3", bus.br_wr_data, 64'h4444444444444444);
        chk("t2_not_done_yet", {63'd0, bus.c0_done}, 64'd0);
        step();
        bus.c0_wr_data = 64'hDEAD; bus.br_rd_data_valid = 0;
        #1;
        chk("t2_done", {63'd0, bus.c0_done}, 64'd1);
        chk("t2_idle_wr_data", bus.br_wr_data, 64'd0);

        // 3: both request after reset -> c0, c1, then c0 again, spacing 14
        rst = 1;
        idle(2);
        rst = 0;
        bus.c0_req = 1; bus.c0_cmd = 0; bus.c0_addr = 21'h000300;
        bus.c1_req = 1; bus.c1_cmd = 0; bus.c1_addr = 21'h000400;
        wait_cmd(t0);
        chk("t3_first_c0", {62'd0, bus.c1_gnt, bus.c0_gnt}, 64'b01);
        chk("t3_first_addr", {43'd0, bus.br_addr}, 64'h300);
        bus.c0_req = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            bus.br_rd_data_valid = 1; bus.br_rd_data = 64'hB0 + 64'(k);
        end
        step();
        bus.br_rd_data_valid = 0;
        #1;
        chk("t3_c0_done", {62'd0, bus.c1_done, bus.c0_done}, 64'b01);
        wait_cmd(t1);
        chk("t3_spacing_c1", 64'(t1 - t0), 64'd14);
        chk("t3_second_c1", {62'd0, bus.c1_gnt, bus.c0_gnt}, 64'b10);
        chk("t3_second_addr", {43'd0, bus.br_addr}, 64'h400);
        // c1 keeps requesting (a write) while c0 raises a new write
        bus.c1_cmd = 1; bus.c1_addr = 21'h000410;
        bus.c0_req = 1; bus.c0_cmd = 1; bus.c0_addr = 21'h000310;
        for (int k = 0; k < 4; k++) begin
            step();
            bus.br_rd_data_valid = 1; bus.br_rd_data = 64'hC0 + 64'(k);
            #1;
            chk("t3_c1_valid", {62'd0, bus.c1_rd_data_valid, bus.c0_rd_data_valid}, 64'b10);
        end
        step();
        bus.br_rd_data_valid = 0;
        #1;
        chk("t3_c1_done", {62'd0, bus.c1_done, bus.c0_done}, 64'b10);
        wait_cmd(t2);
        chk("t3_spacing_c0", 64'(t2 - t1), 64'd14);
        chk("t3_rr_c0", {62'd0, bus.c1_gnt, bus.c0_gnt}, 64'b01);
        chk("t3_rr_addr", {42'd0, bus.br_addr, bus.br_cmd}, {42'd0, 21'h000310, 1'b1});
        bus.c0_req = 0;
        wait_cmd(t3);
        chk("t3_spacing_c1b", 64'(t3 - t2), 64'd14);
        chk("t3_rr_c1", {62'd0, bus.c1_gnt, bus.c0_gnt}, 64'b10);
        bus.c1_req = 0;
        idle(16);

        // 4: c1 request at T+3 of a c0 write waits the full spacing
        bus.c0_req = 1; bus.c0_cmd = 1; bus.c0_addr = 21'h000500;
        wait_cmd(t0);
        bus.c0_req = 0;
        idle(3);
        bus.c1_req = 1; bus.c1_cmd = 0; bus.c1_addr = 21'h000600;
        step(); #1;
        chk("t4_c0_done", {63'd0, bus.c0_done}, 64'd1);
        chk("t4_no_cmd_at_done", {63'd0, bus.br_cmd_en}, 64'd0);
        wait_cmd(t1);
        chk("t4_spacing", 64'(t1 - t0), 64'd14);
        chk("t4_c1_gnt", {62'd0, bus.c1_gnt, bus.c0_gnt}, 64'b10);
        bus.c1_req = 0;

        // 5: reset after beat 2 of the c1 read
        for (int k = 0; k < 2; k++) begin
            step();
            bus.br_rd_data_valid = 1; bus.br_rd_data = 64'hD0 + 64'(k);
            #1;
            chk("t5_c1_valid", {63'd0, bus.c1_rd_data_valid}, 64'd1);
        end
        step();
        bus.br_rd_data_valid = 0; rst = 1;
        step();
        rst = 0;
        bus.br_rd_data_valid = 1;
        bus.c0_req = 1; bus.c0_cmd = 1; bus.c0_addr = 21'h000700;
        #1;
        chk("t5_rst_outputs", {40'd0, bus.br_cmd_en, bus.br_cmd, bus.br_addr,
                               bus.c0_gnt, bus.c1_gnt, bus.c0_done, bus.c1_done}, 64'd0);
        chk("t5_late_beat3", {62'd0, bus.c1_rd_data_valid, bus.c0_rd_data_valid}, 64'd0);
        step(); #1;
        chk("t5_late_beat4", {62'd0, bus.c1_rd_data_valid, bus.c0_rd_data_valid}, 64'd0);
        chk("t5_immediate_gnt", {62'd0, bus.br_cmd_en, bus.c0_gnt}, 64'b11);
        bus.c0_req = 0; bus.br_rd_data_valid = 0;
        idle(5);

        // 6: stray beats in IDLE, then a fresh read still needs exactly 4 beats
        bus.br_rd_data_valid = 1;
        #1;
        chk("t6_idle_valid", {62'd0, bus.c1_rd_data_valid, bus.c0_rd_data_valid}, 64'd0);
        step(); #1;
        chk("t6_idle_no_cmd", {61'd0, bus.br_cmd_en, bus.c1_done, bus.c0_done}, 64'd0);
        bus.br_rd_data_valid = 0;
        idle(12);
        bus.c1_req = 1; bus.c1_cmd = 0; bus.c1_addr = 21'h000800;
        wait_cmd(t0);
        chk("t6_c1_gnt", {62'd0, bus.c1_gnt, bus.c0_gnt}, 64'b10);
        bus.c1_req = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            bus.br_rd_data_valid = 1;
            #1;
            chk("t6_not_done_early", {63'd0, bus.c1_done}, 64'd0);
        end
        step();
        bus.br_rd_data_valid = 0;
        #1;
        chk("t6_done_after_4", {62'd0, bus.c1_done, bus.c0_done}, 64'b10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
